// File: rtl/mm_host_ctrl.sv
// Host-side sequencer for the matrix multiplier: loads A/B words into the MA/MB
// port-B memories, pulses Go, waits for Done (with timeout) and streams MULT_OUT out.
module mm_host_ctrl #(
   parameter int DATA_W  = 128,
   parameter int ADDR_W  = 1,
   parameter int WORDS   = 1,
   parameter int RES_W   = 512,
   parameter int OUT_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [DATA_W-1:0] In_data,
   input  logic              In_valid,
   output logic              In_ready,
   output logic [OUT_W-1:0]  Out_data,
   output logic              Out_valid,
   input  logic              Out_ready,
   output logic              Out_last,
   output logic              Busy,
   output logic              Err,
   output logic              Go,
   input  logic              Done,
   input  logic [RES_W-1:0]  Mult_out,
   output logic              Rst_Core,
   output logic              Rst_M,
   output logic [DATA_W-1:0] MA_dib,
   output logic [DATA_W-1:0] MB_dib,
   output logic [ADDR_W-1:0] MA_Addrb,
   output logic [ADDR_W-1:0] MB_Addrb,
   output logic              MA_enb,
   output logic              MB_enb,
   output logic              MA_web,
   output logic              MB_web
);

   localparam int CW     = ADDR_W + 1;
   localparam int TW     = $clog2(TIMEOUT) + 1;
   localparam int NBEATS = RES_W / OUT_W;
   localparam int BW     = $clog2(NBEATS) + 1;
   localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
   localparam logic [CW-1:0] ALL_WORDS = CW'(WORDS);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [BW-1:0] PEN_BEAT  = BW'(NBEATS - 2);

   // Handshake: a transfer happens on a rising Clk edge where valid and ready are both high;
   // valid and its data stay stable until that edge.
   typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_DRAIN} state_t;

   state_t           state;
   logic [CW-1:0]    word_cnt;
   logic [TW-1:0]    tmo_cnt;
   logic [BW-1:0]    beat_cnt;
   logic [RES_W-1:0] res_buf;
   logic             accept;

   assign accept   = In_valid & In_ready;
   assign Out_data = res_buf[RES_W-1 -: OUT_W];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= S_IDLE;
         word_cnt  <= '0;
         tmo_cnt   <= '0;
         beat_cnt  <= '0;
         res_buf   <= '0;
         In_ready  <= 1'b0;
         Out_valid <= 1'b0;
         Out_last  <= 1'b0;
         Busy      <= 1'b0;
         Err       <= 1'b0;
         Go        <= 1'b0;
         Rst_Core  <= 1'b1;
         Rst_M     <= 1'b1;
         MA_dib    <= '0;
         MB_dib    <= '0;
         MA_Addrb  <= '0;
         MB_Addrb  <= '0;
         MA_enb    <= 1'b0;
         MB_enb    <= 1'b0;
         MA_web    <= 1'b0;
         MB_web    <= 1'b0;
      end else begin
         Rst_M  <= 1'b0;
         MA_enb <= 1'b0;
         MA_web <= 1'b0;
         MB_enb <= 1'b0;
         MB_web <= 1'b0;
         case (state)
            S_IDLE, S_LOAD_A: begin
               if (state == S_IDLE) In_ready <= ~Rst_M;
               if (accept) begin
                  Err      <= 1'b0;
                  Busy     <= 1'b1;
                  MA_enb   <= 1'b1;
                  MA_web   <= 1'b1;
                  MA_Addrb <= word_cnt[ADDR_W-1:0];
                  MA_dib   <= In_data;
                  if (word_cnt == LAST_WORD) begin
                     word_cnt <= '0;
                     state    <= S_LOAD_B;
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                     state    <= S_LOAD_A;
                  end
               end
            end
            S_LOAD_B: begin
               // word_cnt == WORDS marks the cycle carrying the final B strobe
               if (word_cnt == ALL_WORDS) begin
                  word_cnt <= '0;
                  tmo_cnt  <= '0;
                  Go       <= 1'b1;
                  Rst_Core <= 1'b0;
                  state    <= S_START;
               end else if (accept) begin
                  MB_enb   <= 1'b1;
                  MB_web   <= 1'b1;
                  MB_Addrb <= word_cnt[ADDR_W-1:0];
                  MB_dib   <= In_data;
                  word_cnt <= word_cnt + 1'b1;
                  if (word_cnt == LAST_WORD) In_ready <= 1'b0;
               end
            end
            S_START: begin
               Go      <= 1'b0;
               tmo_cnt <= tmo_cnt + 1'b1;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (Done) begin
                  res_buf   <= Mult_out;
                  Out_valid <= 1'b1;
                  Out_last  <= (NBEATS == 1);
                  beat_cnt  <= '0;
                  Rst_Core  <= 1'b1;
                  state     <= S_DRAIN;
               end else if (tmo_cnt == TO_LAST) begin
                  Err      <= 1'b1;
                  Rst_Core <= 1'b1;
                  Busy     <= 1'b0;
                  In_ready <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (Out_valid && Out_ready) begin
                  res_buf <= {res_buf[RES_W-OUT_W-1:0], {OUT_W{1'b0}}};
                  if (Out_last) begin
                     Out_valid <= 1'b0;
                     Out_last  <= 1'b0;
                     Busy      <= 1'b0;
                     In_ready  <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     Out_last <= (beat_cnt == PEN_BEAT);
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_host_ctrl.sv
// Self-checking bench for mm_host_ctrl: random load/compute/drain operations scored
// against a memory mirror and an expected-word queue built from the result value.
module tb_mm_host_ctrl;

   localparam int DATA_W  = 128;
   localparam int ADDR_W  = 1;
   localparam int WORDS   = 1;
   localparam int RES_W   = 512;
   localparam int OUT_W   = 32;
   localparam int TIMEOUT = 1024;
   localparam int NBEATS  = RES_W / OUT_W;

   logic              Clk, Rst_n;
   logic [DATA_W-1:0] In_data;
   logic              In_valid, In_ready;
   logic [OUT_W-1:0]  Out_data;
   logic              Out_valid, Out_ready, Out_last;
   logic              Busy, Err, Go, Done;
   logic [RES_W-1:0]  Mult_out;
   logic              Rst_Core, Rst_M;
   logic [DATA_W-1:0] MA_dib, MB_dib;
   logic [ADDR_W-1:0] MA_Addrb, MB_Addrb;
   logic              MA_enb, MB_enb, MA_web, MB_web;

   mm_host_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS(WORDS),
      .RES_W(RES_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .In_data(In_data), .In_valid(In_valid), .In_ready(In_ready),
      .Out_data(Out_data), .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_last(Out_last),
      .Busy(Busy), .Err(Err), .Go(Go), .Done(Done), .Mult_out(Mult_out),
      .Rst_Core(Rst_Core), .Rst_M(Rst_M),
      .MA_dib(MA_dib), .MB_dib(MB_dib), .MA_Addrb(MA_Addrb), .MB_Addrb(MB_Addrb),
      .MA_enb(MA_enb), .MB_enb(MB_enb), .MA_web(MA_web), .MB_web(MB_web)
   );

   // clock / watchdog
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // scoreboard state
   logic [OUT_W-1:0]  exp_q[$];
   logic [DATA_W-1:0] ma_mem[2];
   logic [DATA_W-1:0] mb_mem[2];
   int                ma_wr, mb_wr, go_cnt, n_beats;
   bit                out_seen, prev_stall;
   logic [OUT_W-1:0]  prev_data;

   always @(negedge Clk) begin
      if (Rst_n) begin
         if (MA_enb && MA_web) begin ma_mem[MA_Addrb] = MA_dib; ma_wr++; end
         if (MB_enb && MB_web) begin mb_mem[MB_Addrb] = MB_dib; mb_wr++; end
         if (Go) go_cnt++;
         if (Out_valid) out_seen = 1'b1;
         if (prev_stall) begin
            check("hold_valid", 512'(Out_valid), 512'(1));
            check("hold_data", 512'(Out_data), 512'(prev_data));
         end
         if (Out_valid && Out_ready) begin
            n_beats++;
            if (exp_q.size() > 0) begin
               logic [OUT_W-1:0] e;
               e = exp_q.pop_front();
               check("out_data", 512'(Out_data), 512'(e));
               check("out_last", 512'(Out_last), 512'(exp_q.size() == 0));
            end
         end
         prev_stall = Out_valid && !Out_ready;
         prev_data  = Out_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   function automatic logic [511:0] rand_wide(input int nwords);
      logic [511:0] r = '0;
      for (int i = 0; i < nwords; i++) r = (r << 32) | 512'($urandom());
      return r;
   endfunction

   task automatic check_reset(input string ph);
      check({ph, "_rst_core"}, 512'(Rst_Core), 512'(1));
      check({ph, "_rst_m"}, 512'(Rst_M), 512'(1));
      check({ph, "_ctrl"}, 512'({In_ready, Out_valid, Out_last, Busy, Err, Go}), 512'(0));
      check({ph, "_mem_if"}, 512'({MA_enb, MB_enb, MA_web, MB_web, MA_Addrb, MB_Addrb}), 512'(0));
      check({ph, "_data"}, 512'({MA_dib, MB_dib, Out_data}), 512'(0));
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] d);
      bit acc = 1'b0;
      In_data  = d;
      In_valid = 1'b1;
      for (int t = 0; t < 20 && !acc; t++) begin
         acc = In_ready;
         tick();
      end
      check("in_accept", 512'(acc), 512'(1));
      In_valid = 1'b0;
      In_data  = DATA_W'(rand_wide(4));
   endtask

   // dly >= 1: Done that many cycles after Go; -1: never; -2: reset while waiting
   task automatic run_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input int gap, input int dly, input bit bp,
                         input logic [RES_W-1:0] res);
      int t;
      bit drained;
      ma_mem[0] = '0; ma_mem[1] = '0; mb_mem[0] = '0; mb_mem[1] = '0;
      ma_wr = 0; mb_wr = 0; go_cnt = 0; n_beats = 0; out_seen = 1'b0;
      exp_q.delete();

      send_beat(a);
      check("err_clear", 512'(Err), 512'(0));
      check("busy_load", 512'(Busy), 512'(1));
      for (int g = 0; g < gap; g++) begin
         Done     = 1'b1;
         Mult_out = rand_wide(16);
         tick();
      end
      Done = 1'b0;
      send_beat(b);
      check("in_ready_drop", 512'(In_ready), 512'(0));

      t = 0;
      while (!Go && t < 10) begin tick(); t++; end
      check("go_latency", 512'(t), 512'(1));
      check("go_rst_core", 512'(Rst_Core), 512'(0));
      check("ma_word0", 512'(ma_mem[0]), 512'(a));
      check("mb_word0", 512'(mb_mem[0]), 512'(b));
      check("ma_word1", 512'(ma_mem[1]), 512'(0));
      check("wr_strobes", 512'({ma_wr, mb_wr}), 512'({32'd1, 32'd1}));
      tick();
      check("go_single", 512'(Go), 512'(0));
      check("wait_rst_core", 512'(Rst_Core), 512'(0));

      if (dly == -2) begin
         tick();
         #3 Rst_n = 1'b0;
         #1 check_reset("midrst");
         @(posedge Clk);
         #1 Rst_n = 1'b1;
         tick();
         tick();
         check("midrst_in_ready", 512'(In_ready), 512'(1));
      end else if (dly == -1) begin
         t = 1;
         while (!Err && t < TIMEOUT + 20) begin tick(); t++; end
         check("timeout_cycles", 512'(t), 512'(TIMEOUT));
         check("timeout_rst_core", 512'(Rst_Core), 512'(1));
         check("timeout_idle", 512'({Busy, In_ready}), 512'(2'b01));
         check("timeout_no_out", 512'(out_seen), 512'(0));
         repeat (3) tick();
         check("err_sticky", 512'(Err), 512'(1));
      end else begin
         repeat (dly - 1) tick();
         for (int i = 0; i < NBEATS; i++) exp_q.push_back(OUT_W'(res >> (OUT_W * (NBEATS - 1 - i))));
         Done     = 1'b1;
         Mult_out = res;
         tick();
         Done     = 1'b0;
         Mult_out = rand_wide(16);
         drained  = 1'b0;
         for (int k = 0; k < 400 && !drained; k++) begin
            Out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            tick();
            if (k > 0 && exp_q.size() == 0 && !Out_valid) drained = 1'b1;
         end
         Out_ready = 1'b0;
         check("drain_done", 512'(drained), 512'(1));
         check("beat_count", 512'(n_beats), 512'(NBEATS));
         check("post_idle", 512'({Busy, In_ready, Out_valid, Out_last}), 512'(4'b0100));
         check("drain_rst_core", 512'(Rst_Core), 512'(1));
      end
      check("go_total", 512'(go_cnt), 512'(1));
   endtask

   logic [DATA_W-1:0] a_nom, b_nom;
   logic [RES_W-1:0]  res_nom;

   initial begin
      Rst_n = 1'b0; In_valid = 1'b0; In_data = '0;
      Out_ready = 1'b0; Done = 1'b0; Mult_out = '0;
      prev_stall = 1'b0;

      // reset then idle
      repeat (3) tick();
      check_reset("reset");
      Rst_n = 1'b1;
      tick();
      check("rst_m_release", 512'(Rst_M), 512'(0));
      check("in_ready_early", 512'(In_ready), 512'(0));
      tick();
      check("in_ready_idle", 512'(In_ready), 512'(1));
      check("idle_ctrl", 512'({Busy, Err, Go, Out_valid, Rst_Core}), 512'(5'b00001));

      a_nom = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
      b_nom = {8{16'h0001}};
      for (int i = 0; i < NBEATS; i++) res_nom[RES_W - 1 - OUT_W * i -: OUT_W] = OUT_W'(i);

      run_op(a_nom, b_nom, 0, 5, 1'b0, res_nom);                        // nominal
      run_op(DATA_W'(rand_wide(4)), DATA_W'(rand_wide(4)), 0, 5, 1'b1, res_nom); // backpressure
      run_op(DATA_W'(rand_wide(4)), DATA_W'(rand_wide(4)), 2, 3, 1'b0, rand_wide(16)); // input gap
      run_op(DATA_W'(rand_wide(4)), DATA_W'(rand_wide(4)), 0, -1, 1'b0, '0); // timeout
      run_op(a_nom, b_nom, 0, 5, 1'b0, res_nom);                        // clears Err
      run_op(DATA_W'(rand_wide(4)), DATA_W'(rand_wide(4)), 1, -2, 1'b0, '0); // reset mid-run
      run_op(a_nom, b_nom, 0, 5, 1'b0, res_nom);

      for (int r = 0; r < 8; r++)
         run_op(DATA_W'(rand_wide(4)), DATA_W'(rand_wide(4)), $urandom_range(0, 3),
                $urandom_range(1, 30), 1'($urandom_range(0, 1)), rand_wide(16));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mm_host_ctrl.md
Name: mm_host_ctrl

Overview:
- Hardware host-side sequencer for multiplynnMatrix_Top. It performs in RTL the job the bench does today.
- Accepts matrix A and matrix B words over a valid/ready input stream and writes them into the MA/MB port-B memory interfaces.
- Pulses Go, waits for Done with a timeout, captures the 512-bit MULT_OUT, and streams it out as 32-bit words over valid/ready.
- Sits between a bus/DMA front end and the multiplier top.

Parameters:
DATA_W, 128, width of one matrix memory word (MA/MB dib).
ADDR_W, 1, MA/MB port-B address width.
WORDS, 1, 128-bit words per matrix; legal range 1..2**ADDR_W.
RES_W, 512, width of MULT_OUT.
OUT_W, 32, output stream word width; RES_W must be a multiple of OUT_W.
TIMEOUT, 1024, maximum cycles in WAIT before abort.

Ports:
Clk  in  1  system clock, rising edge.
Rst_n  in  1  asynchronous active-low reset.
In_data  in  DATA_W  matrix word; A words first, then B words.
In_valid  in  1  In_data valid.
In_ready  out  1  block accepts In_data this cycle.
Out_data  out  OUT_W  result word.
Out_valid  out  1  Out_data valid.
Out_ready  in  1  downstream accepts Out_data.
Out_last  out  1  marks the final result word.
Busy  out  1  high in any state other than IDLE.
Err  out  1  sticky timeout flag.
Go  out  1  start pulse to the multiplier.
Done  in  1  multiplier completion.
Mult_out  in  RES_W  multiplier result.
Rst_Core  out  1  active-high core reset.
Rst_M  out  1  active-high memory reset.
MA_dib, MB_dib  out  DATA_W  port-B write data.
MA_Addrb, MB_Addrb  out  ADDR_W  port-B address.
MA_enb, MB_enb, MA_web, MB_web  out  1  port-B enable and write enable.

Behaviour:
- Reset values (all applied asynchronously while Rst_n is low):
  - Rst_Core=1, Rst_M=1.
  - All other outputs 0, including In_ready, Out_valid, Out_last, Busy, Err, Go, enables, addresses and data.
  - FSM in IDLE; word counter=0.
- Rst_M deasserts on the first Clk edge after Rst_n rises. It is never reasserted except by Rst_n.
- FSM states: IDLE, LOAD_A, LOAD_B, START, WAIT, DRAIN.
- IDLE:
  - In_ready=1 once Rst_M=0.
  - A beat is accepted when In_valid and In_ready are both high. The first accepted beat clears Err and enters LOAD_A, counting as A word 0.
- LOAD_A / LOAD_B:
  - In_ready=1.
  - Each accepted beat drives a registered write on the next cycle: MA_enb=MA_web=1 (or MB_enb=MB_web=1), MA_Addrb/MB_Addrb = word index, dib = the beat data. Write strobes last exactly one cycle per beat.
  - No beat accepted means enb=web=0.
  - After WORDS A beats go to LOAD_B. After WORDS B beats go to START; In_ready drops in the same cycle the last B beat is accepted.
- START:
  - Lasts one cycle, entered after the final B write strobe has been issued.
  - Rst_Core=0 and Go=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Rst_Core stays 0; the timeout counter increments every cycle.
  - Done=1: register Mult_out into a RES_W shift buffer and go to DRAIN. Done is sampled only in WAIT; Done in other states is ignored.
  - Counter reaches TIMEOUT-1 without Done: set Err=1, Rst_Core=1, return to IDLE. No output is produced.
  - If Done and timeout occur in the same cycle, Done wins.
- DRAIN:
  - Rst_Core returns to 1.
  - Out_valid=1. Out_data = most-significant OUT_W slice first, i.e. Mult_out[511:480], then [479:448], and so on.
  - The buffer shifts only on Out_valid and Out_ready both high. Out_data and Out_valid must stay stable while Out_ready is low.
  - Out_last=1 on beat RES_W/OUT_W (the 16th beat by default).
  - When the last beat is accepted, Out_valid drops next cycle and the FSM returns to IDLE.
- Busy=1 in every state except IDLE.
- Rst_n asserted mid-operation aborts immediately to reset values; a partially loaded matrix is discarded.
- Counter widths: word counter is ADDR_W+1 bits; timeout counter is clog2(TIMEOUT)+1 bits.

Test Plan:
1. Reset then idle: Rst_n low for 3 cycles, then high -> Rst_M=1 during reset and 0 one cycle after release; all other outputs 0; In_ready=1 from the cycle after Rst_M falls.
2. Nominal run:
   - Stimulus: A=128'h0001_0002_0003_0004_0005_0006_0007_0008, B=128'h0001 repeated in all eight 16-bit lanes; model Done 5 cycles after Go, Mult_out=512'h00..01_..._0F (word i = i).
   - Response: one MA write and one MB write at address 0; a single-cycle Go; then 16 Out beats in order 32'h0 first through 32'hF, with Out_last on the 16th.
3. Backpressure: Out_ready toggled 1,0,0,1 repeating during DRAIN -> Out_data held stable while stalled; no beat lost or duplicated; 16 beats total.
4. Input gaps: In_valid low for 2 cycles between the A and B beats -> no write strobes during the gap; correct data and addresses; Go issued once.
5. Timeout: Done never asserted -> Err=1 and Rst_Core=1 TIMEOUT cycles after Go, return to IDLE with Out_valid never asserted; the next accepted In beat clears Err.
6. Reset mid-run: Rst_n pulled low in WAIT -> all outputs take reset values asynchronously; a full nominal run afterwards passes.
